// File: rtl/toom8_pkg.sv
// Shared widths and FSM encoding for the Toom-8 multiplier datapath.
// Evaluation-side widths sit next to the recomposition widths so both halves stay consistent.
package toom8_pkg;

  localparam int CHUNK_W   = 128;
  localparam int NCOEF     = 15;
  localparam int COEF_W    = 260;
  localparam int CARRY_W   = 133;
  localparam int NLIMB     = NCOEF + 1;
  localparam int PROD_W    = NLIMB * CHUNK_W;

  localparam int OPERAND_W = 1024;
  localparam int NPART     = 8;
  localparam int NPOINT    = 2 * NPART - 1;

  typedef enum logic [1:0] {
    ST_COLLECT,
    ST_FLUSH,
    ST_OUTPUT
  } state_t;

endpackage

// File: rtl/toom8_carry_window.sv
// Adds the running carry to one coefficient and splits the sum into
// the next output limb and the carry forwarded to the following limb.
module toom8_carry_window
  import toom8_pkg::*;
#(
  parameter int CHUNK_W = toom8_pkg::CHUNK_W,
  parameter int COEF_W  = toom8_pkg::COEF_W,
  parameter int CRY_W   = COEF_W + 1 - CHUNK_W
) (
  input  logic [CRY_W-1:0]   i_carry,
  input  logic [COEF_W-1:0]  i_coef,
  output logic [CHUNK_W-1:0] o_limb,
  output logic [CRY_W-1:0]   o_carry
);

  localparam int WIN_W = COEF_W + 1;

  logic [WIN_W-1:0] w_window;

  assign w_window = WIN_W'(i_carry) + WIN_W'(i_coef);
  assign o_limb   = w_window[CHUNK_W-1:0];
  assign o_carry  = w_window[WIN_W-1:CHUNK_W];

endmodule

// File: rtl/toom_8_recompose.sv
// Recomposes interpolated Toom-8 coefficients into the full product,
// one limb per accepted coefficient, then a flush limb from the residual carry.
module toom_8_recompose #(
  parameter int CHUNK_W = toom8_pkg::CHUNK_W,
  parameter int NCOEF   = toom8_pkg::NCOEF,
  parameter int COEF_W  = toom8_pkg::COEF_W
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           coef_valid,
  output logic                           coef_ready,
  input  logic [COEF_W-1:0]              coef_data,
  output logic                           prod_valid,
  input  logic                           prod_ready,
  output logic [(NCOEF+1)*CHUNK_W-1:0]   product,
  output logic                           overflow
);

  import toom8_pkg::*;

  localparam int NLIMB = NCOEF + 1;
  localparam int CRY_W = COEF_W + 1 - CHUNK_W;
  localparam int K_W   = $clog2(NLIMB);

  state_t                     r_state;
  logic [CRY_W-1:0]           r_carry;
  logic [K_W-1:0]             r_k;
  logic [NLIMB*CHUNK_W-1:0]   r_product;
  logic                       r_overflow;
  logic                       r_coef_ready;
  logic                       r_prod_valid;

  logic                       w_beat;
  logic [CHUNK_W-1:0]         w_win_limb;
  logic [CRY_W-1:0]           w_win_carry;
  logic [NLIMB-1:0]           w_limb_we;
  logic [CHUNK_W-1:0]         w_limb_d [NLIMB];

  // r_coef_ready is only high in COLLECT, so it doubles as the state qualifier.
  assign w_beat = coef_valid & r_coef_ready;

  toom8_carry_window #(
    .CHUNK_W (CHUNK_W),
    .COEF_W  (COEF_W),
    .CRY_W   (CRY_W)
  ) u_window (
    .i_carry (r_carry),
    .i_coef  (coef_data),
    .o_limb  (w_win_limb),
    .o_carry (w_win_carry)
  );

  for (genvar gi = 0; gi < NLIMB; gi++) begin : g_limb
    if (gi == NLIMB - 1) begin : g_flush
      assign w_limb_we[gi] = (r_state == ST_FLUSH);
      assign w_limb_d[gi]  = r_carry[CHUNK_W-1:0];
    end else begin : g_beat
      assign w_limb_we[gi] = w_beat && (r_k == K_W'(gi));
      assign w_limb_d[gi]  = w_win_limb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_product <= '0;
    end else begin
      for (int i = 0; i < NLIMB; i++) begin
        if (w_limb_we[i]) r_product[i*CHUNK_W +: CHUNK_W] <= w_limb_d[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_COLLECT;
      r_carry      <= '0;
      r_k          <= '0;
      r_overflow   <= 1'b0;
      r_coef_ready <= 1'b1;
      r_prod_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_COLLECT: begin
          if (w_beat) begin
            r_carry <= w_win_carry;
            r_k     <= r_k + 1'b1;
            if (r_k == K_W'(NCOEF - 1)) begin
              r_state      <= ST_FLUSH;
              r_coef_ready <= 1'b0;
            end
          end
        end
        ST_FLUSH: begin
          r_overflow   <= |r_carry[CRY_W-1:CHUNK_W];
          r_prod_valid <= 1'b1;
          r_state      <= ST_OUTPUT;
        end
        ST_OUTPUT: begin
          // Product limbs are left in place; the next run overwrites them one by one.
          if (prod_ready) begin
            r_carry      <= '0;
            r_k          <= '0;
            r_prod_valid <= 1'b0;
            r_coef_ready <= 1'b1;
            r_state      <= ST_COLLECT;
          end
        end
        default: begin
          r_state      <= ST_COLLECT;
          r_coef_ready <= 1'b1;
          r_prod_valid <= 1'b0;
        end
      endcase
    end
  end

  assign coef_ready = r_coef_ready;
  assign prod_valid = r_prod_valid;
  assign product    = r_product;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_toom_8_recompose.sv
// Directed scoreboard bench for toom_8_recompose: stimulus pushes expected
// products, an independent monitor checks them when the DUT presents a product.
module tb_toom_8_recompose;

  localparam int PW = 2048;
  localparam int CW = 260;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          coef_valid = 1'b0;
  logic          coef_ready;
  logic [CW-1:0] coef_data = '0;
  logic          prod_valid;
  logic          prod_ready = 1'b0;
  logic [PW-1:0] product;
  logic          overflow;

  always #5 clk = ~clk;

  toom_8_recompose dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .coef_data  (coef_data),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .product    (product),
    .overflow   (overflow)
  );

  typedef struct {
    string         name;
    logic [PW-1:0] prod;
    logic          ovf;
    int            lat;
  } exp_t;

  exp_t          sb[$];
  int            checks = 0;
  int            errors = 0;
  logic [CW-1:0] cv [15];

  // Monitor: sole owner of the check counters.
  initial begin : monitor
    int            cyc;
    int            t0;
    int            nbeats;
    int            idle;
    int            lat;
    bit            pv_prev;
    bit            rst_prev;
    logic [PW-1:0] held;
    exp_t          e;
    cyc = 0; t0 = 0; nbeats = 0; idle = 0; pv_prev = 0; rst_prev = 0; held = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        checks++;
        if (product != '0 || overflow !== 1'b0 || prod_valid !== 1'b0) begin
          errors++;
          $display("FAIL reset_outputs product_nonzero=%0b overflow=%0b prod_valid=%0b required 0 0 0",
                   |product, overflow, prod_valid);
        end
        nbeats = 0; pv_prev = 0; rst_prev = 1; idle = 0;
        continue;
      end
      if (rst_prev) begin
        checks++;
        if (coef_ready !== 1'b1) begin
          errors++;
          $display("FAIL ready_after_reset coef_ready=%b required 1", coef_ready);
        end
      end
      rst_prev = 0;
      if (coef_valid && coef_ready) begin
        if (nbeats == 0) t0 = cyc;
        nbeats++;
      end
      if (prod_valid && !pv_prev) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_product prod_valid=1 with nothing expected");
        end else begin
          e = sb[0];
          if (product !== e.prod) begin
            errors++;
            $display("FAIL %s_product diffbits=%0d got_lo=%h req_lo=%h got_hi=%h req_hi=%h",
                     e.name, $countones(product ^ e.prod), product[127:0], e.prod[127:0],
                     product[2047:1920], e.prod[2047:1920]);
          end
          checks++;
          if (overflow !== e.ovf) begin
            errors++;
            $display("FAIL %s_overflow got=%b required=%b", e.name, overflow, e.ovf);
          end
          lat = cyc - t0 + 1;
          checks++;
          if (lat != e.lat) begin
            errors++;
            $display("FAIL %s_latency got=%0d required=%0d", e.name, lat, e.lat);
          end
          $display("product %s checked latency=%0d overflow=%b", e.name, lat, overflow);
        end
        held = product;
      end else if (prod_valid) begin
        checks++;
        if (product !== held || coef_ready !== 1'b0) begin
          errors++;
          $display("FAIL output_hold product_changed=%0b coef_ready=%b required 0 0",
                   product !== held, coef_ready);
        end
      end
      if (prod_valid && prod_ready) begin
        if (sb.size() > 0) void'(sb.pop_front());
        nbeats = 0;
        idle = 0;
      end
      if (sb.size() > 0 && !prod_valid) begin
        idle++;
        if (idle > 80) begin
          checks++;
          errors++;
          $display("FAIL %s_timeout no prod_valid within 80 cycles", sb[0].name);
          void'(sb.pop_front());
          idle = 0;
          nbeats = 0;
        end
      end else begin
        idle = 0;
      end
      pv_prev = prod_valid;
    end
  end

  task automatic clear_cv();
    for (int k = 0; k < 15; k++) cv[k] = '0;
  endtask

  task automatic send(input int n, input bit gaps, input bit junk);
    int i;
    int guard;
    bit ph;
    i = 0; guard = 0; ph = 1'b1;
    @(posedge clk); #1;
    coef_valid = 1'b1;
    coef_data  = cv[0];
    while (i < n && guard < 200) begin
      @(negedge clk);
      guard++;
      if (coef_valid && coef_ready) i++;
      @(posedge clk); #1;
      if (gaps) ph = ~ph;
      if (i < n) begin
        coef_valid = gaps ? ph : 1'b1;
        coef_data  = cv[i];
      end else begin
        coef_valid = junk;
        coef_data  = junk ? '1 : '0;
      end
    end
  endtask

  task automatic drain(input int delay);
    int w;
    w = 0;
    while (!prod_valid && w < 60) begin
      @(negedge clk);
      w++;
    end
    if (prod_valid) begin
      repeat (delay) @(posedge clk);
      @(posedge clk); #1;
      prod_ready = 1'b1;
      coef_valid = 1'b0;
      @(posedge clk); #1;
      prod_ready = 1'b0;
    end
    coef_valid = 1'b0;
  endtask

  task automatic run(input string nm, input logic [PW-1:0] ep, input logic eo, input int lat,
                     input bit gaps, input bit junk, input int delay);
    exp_t e;
    e.name = nm; e.prod = ep; e.ovf = eo; e.lat = lat;
    sb.push_back(e);
    send(15, gaps, junk);
    drain(delay);
  endtask

  initial begin : stimulus
    logic [CW-1:0] m;
    logic [PW-1:0] a;
    logic [PW-1:0] e;
    int            mk;

    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    clear_cv();
    run("zero", '0, 1'b0, 17, 1'b0, 1'b0, 0);

    clear_cv();
    cv[0] = 260'd1;
    e = '0; e[0] = 1'b1;
    run("c0_one", e, 1'b0, 17, 1'b0, 1'b0, 0);

    clear_cv();
    cv[1] = '0; cv[1][256] = 1'b1;
    e = '0; e[384] = 1'b1;
    run("c1_bit256", e, 1'b0, 17, 1'b0, 1'b0, 0);

    clear_cv();
    cv[0] = '1;
    e = '0; e[259:0] = '1;
    run("c0_full", e, 1'b0, 17, 1'b0, 1'b0, 0);

    clear_cv();
    e = '0;
    for (int k = 0; k < 15; k++) begin
      cv[k] = CW'(k + 1);
      e[k*128 +: 128] = 128'(k + 1);
    end
    run("ramp", e, 1'b0, 17, 1'b0, 1'b0, 0);

    // (2^128-1)^2 scaled by the Toom-8 convolution weights 1..8..1
    m = '0; m[127:0] = '1;
    m = m * m;
    for (int k = 0; k < 15; k++) begin
      mk = ((k < 14 - k) ? k : 14 - k) + 1;
      cv[k] = m * CW'(mk);
    end
    a = '0; a[1023:0] = '1;
    e = a * a;
    run("square_stall_junk", e, 1'b0, 17, 1'b0, 1'b1, 5);
    run("square_gaps", e, 1'b0, 31, 1'b1, 1'b0, 0);

    clear_cv();
    cv[14] = '0; cv[14][259] = 1'b1;
    run("overflow", '0, 1'b1, 17, 1'b0, 1'b0, 0);

    // abort mid-collection with the square coefficients, then rerun cleanly
    for (int k = 0; k < 15; k++) begin
      mk = ((k < 14 - k) ? k : 14 - k) + 1;
      cv[k] = m * CW'(mk);
    end
    send(7, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    run("square_after_reset", e, 1'b0, 17, 1'b0, 1'b0, 0);

    repeat (100) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
